// File: rtl/hb3_pkg.sv
// Shared types and helpers for the PmodHB3 motor controller.
// FSM states, edge-mode selectors and a counter-width helper.
package hb3_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DEAD_PRE  = 2'd1,
    DEAD_POST = 2'd2
  } hb3_state_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_BOTH = 1;

  // Bits needed for a counter running 0..n-1 (never below 1).
  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hb3_edge_counter.sv
// Hall-sensor path: synchronisers, edge detect, gated pulse count
// and quadrature direction sense.
module hb3_edge_counter
  import hb3_pkg::*;
#(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int EDGE_MODE   = 0,
  parameter int CNT_W       = 32
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             SA,
  input  logic             SB,
  output logic [CNT_W-1:0] pulse_count,
  output logic             count_valid,
  output logic             meas_dir
);

  localparam int GW = cw(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  logic [1:0]       sa_sync;
  logic [1:0]       sb_sync;
  logic             sa_d;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_inc;
  logic             rise;
  logic             cnt_edge;
  logic             gate_end;

  assign rise     = sa_sync[1] & ~sa_d;
  assign cnt_edge = (EDGE_MODE == EDGE_BOTH) ? (sa_sync[1] ^ sa_d) : rise;
  assign gate_end = (gate_cnt == GATE_LAST);
  assign acc_inc  = (cnt_edge && (acc != '1)) ? acc + CNT_W'(1) : acc;

  // Two-flop synchronisers plus a delayed copy of SA for edge detect.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      sa_sync <= '0;
      sb_sync <= '0;
      sa_d    <= 1'b0;
    end else begin
      sa_sync <= {sa_sync[0], SA};
      sb_sync <= {sb_sync[0], SB};
      sa_d    <= sa_sync[1];
    end
  end

  // Free-running gate timer.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      gate_cnt <= '0;
    end else if (gate_end) begin
      gate_cnt <= '0;
    end else begin
      gate_cnt <= gate_cnt + GW'(1);
    end
  end

  // Accumulate edges; an edge on the closing cycle goes into that gate.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      acc         <= '0;
      pulse_count <= '0;
      count_valid <= 1'b0;
    end else if (gate_end) begin
      acc         <= '0;
      pulse_count <= acc_inc;
      count_valid <= 1'b1;
    end else begin
      acc         <= acc_inc;
      count_valid <= 1'b0;
    end
  end

  // SB level at each SA rise gives rotation direction.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      meas_dir <= 1'b0;
    end else if (rise) begin
      meas_dir <= sb_sync[1];
    end
  end

endmodule

// File: rtl/hb3_motor_ctrl.sv
// PmodHB3 H-bridge controller: PWM on En, dead-time direction
// reversal on Dir, and hall-sensor pulse counting.
module hb3_motor_ctrl
  import hb3_pkg::*;
#(
  parameter int PWM_PERIOD  = 100,
  parameter int DUTY_W      = 7,
  parameter int GATE_CYCLES = 100_000_000,
  parameter int DEADTIME    = 1000,
  parameter int EDGE_MODE   = 0,
  parameter int CNT_W       = 32
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic [DUTY_W-1:0] duty_cycle,
  input  logic              dir_req,
  input  logic              SA,
  input  logic              SB,
  output logic              Dir,
  output logic              En,
  output logic              dir_busy,
  output logic [CNT_W-1:0]  pulse_count,
  output logic              count_valid,
  output logic              meas_dir
);

  localparam int PW = cw(PWM_PERIOD);
  localparam int DW = cw(PWM_PERIOD + 1);
  localparam int TW = cw(DEADTIME);
  localparam logic [PW-1:0] PWM_LAST = PW'(PWM_PERIOD - 1);
  localparam logic [TW-1:0] DT_LAST  = TW'(DEADTIME - 1);

  hb3_state_e    state;
  hb3_state_e    state_n;
  logic [TW-1:0] dead_cnt;
  logic [TW-1:0] dead_cnt_n;
  logic          dir_n;
  logic [PW-1:0] pwm_cnt;
  logic [DW-1:0] duty_act;
  logic [DW-1:0] duty_clamp;

  assign dir_busy = (state != RUN);

  // Clamp the request so duty >= period means always on.
  always_comb begin
    duty_clamp = DW'(duty_cycle);
    if (int'(duty_cycle) >= PWM_PERIOD) begin
      duty_clamp = DW'(PWM_PERIOD);
    end
  end

  // PWM counter; duty only changes at the period boundary.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      pwm_cnt  <= '0;
      duty_act <= '0;
    end else if (pwm_cnt == PWM_LAST) begin
      pwm_cnt  <= '0;
      duty_act <= duty_clamp;
    end else begin
      pwm_cnt  <= pwm_cnt + PW'(1);
    end
  end

  // En drops on the same edge the FSM leaves RUN.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      En <= 1'b0;
    end else begin
      En <= (32'(pwm_cnt) < 32'(duty_act)) && (state_n == RUN);
    end
  end

  // Direction FSM state, dead timer and Dir pin.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state    <= RUN;
      dead_cnt <= '0;
      Dir      <= 1'b0;
    end else begin
      state    <= state_n;
      dead_cnt <= dead_cnt_n;
      Dir      <= dir_n;
    end
  end

  // Reversal sequencing: quiet En, swap Dir mid-way, quiet again.
  always_comb begin
    state_n    = state;
    dead_cnt_n = dead_cnt;
    dir_n      = Dir;
    unique case (state)
      RUN: begin
        if (dir_req != Dir) begin
          state_n    = DEAD_PRE;
          dead_cnt_n = '0;
        end
      end
      DEAD_PRE: begin
        if (dead_cnt == DT_LAST) begin
          dir_n      = dir_req;
          state_n    = DEAD_POST;
          dead_cnt_n = '0;
        end else begin
          dead_cnt_n = dead_cnt + TW'(1);
        end
      end
      DEAD_POST: begin
        if (dead_cnt == DT_LAST) begin
          state_n    = RUN;
          dead_cnt_n = '0;
        end else begin
          dead_cnt_n = dead_cnt + TW'(1);
        end
      end
      default: begin
        state_n    = RUN;
        dead_cnt_n = '0;
      end
    endcase
  end

  hb3_edge_counter #(
    .GATE_CYCLES (GATE_CYCLES),
    .EDGE_MODE   (EDGE_MODE),
    .CNT_W       (CNT_W)
  ) u_edge (
    .Clk         (Clk),
    .Resetn      (Resetn),
    .SA          (SA),
    .SB          (SB),
    .pulse_count (pulse_count),
    .count_valid (count_valid),
    .meas_dir    (meas_dir)
  );

endmodule

// File: tb/tb_hb3_motor_ctrl.sv
// Self-checking bench for hb3_motor_ctrl: two instances share the
// inputs, one counting rising SA edges and one counting both.
module tb_hb3_motor_ctrl;

  logic       Clk = 1'b0;
  logic       Resetn = 1'b0;
  logic [6:0] duty_cycle = '0;
  logic       dir_req = 1'b0;
  logic       SA = 1'b0;
  logic       SB = 1'b0;

  logic        dir_a, en_a, busy_a, cv_a, md_a;
  logic        dir_b, en_b, busy_b, cv_b, md_b;
  logic [31:0] pc_a, pc_b;

  int n_chk = 0;
  int n_pass = 0;
  int exp_q[$];

  always #5 Clk = ~Clk;

  hb3_motor_ctrl #(
    .PWM_PERIOD (100), .DUTY_W (7), .GATE_CYCLES (1000),
    .DEADTIME (10), .EDGE_MODE (0), .CNT_W (32)
  ) dut (
    .Clk (Clk), .Resetn (Resetn), .duty_cycle (duty_cycle),
    .dir_req (dir_req), .SA (SA), .SB (SB),
    .Dir (dir_a), .En (en_a), .dir_busy (busy_a),
    .pulse_count (pc_a), .count_valid (cv_a), .meas_dir (md_a)
  );

  hb3_motor_ctrl #(
    .PWM_PERIOD (100), .DUTY_W (7), .GATE_CYCLES (1000),
    .DEADTIME (10), .EDGE_MODE (1), .CNT_W (32)
  ) dut_b (
    .Clk (Clk), .Resetn (Resetn), .duty_cycle (duty_cycle),
    .dir_req (dir_req), .SA (SA), .SB (SB),
    .Dir (dir_b), .En (en_b), .dir_busy (busy_b),
    .pulse_count (pc_b), .count_valid (cv_b), .meas_dir (md_b)
  );

  task automatic wait_en_rise(output bit ok);
    logic prev;
    ok = 1'b0;
    prev = en_a;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (en_a && !prev) begin
        ok = 1'b1;
        break;
      end
      prev = en_a;
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge Clk);
      if (cv_a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic measure(input int chg_at, input logic [6:0] nd,
                         output int highs, output int runs);
    logic prev;
    highs = 0;
    runs = 0;
    prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) @(negedge Clk);
      if (i == chg_at) duty_cycle = nd;
      if (en_a) highs++;
      if (en_a && !prev) runs++;
      prev = en_a;
    end
  endtask

  task automatic drive_pulses(input int n, input bit lead);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < 20; i++) begin
        SA = (i < 10);
        SB = lead ? ((i < 5) || (i >= 15)) : ((i >= 5) && (i < 15));
        @(negedge Clk);
      end
    end
  endtask

  task automatic test_reset;
    Resetn = 1'b0;
    repeat (3) @(negedge Clk);
    n_chk++; if (dir_a !== 1'b0) $display("FAIL rst_dir got %0b exp 0", dir_a); else n_pass++;
    n_chk++; if (en_a !== 1'b0) $display("FAIL rst_en got %0b exp 0", en_a); else n_pass++;
    n_chk++; if (busy_a !== 1'b0) $display("FAIL rst_busy got %0b exp 0", busy_a); else n_pass++;
    n_chk++; if (pc_a !== 32'd0) $display("FAIL rst_pc got %0d exp 0", pc_a); else n_pass++;
    n_chk++; if (cv_a !== 1'b0) $display("FAIL rst_cv got %0b exp 0", cv_a); else n_pass++;
    n_chk++; if (md_a !== 1'b0) $display("FAIL rst_md got %0b exp 0", md_a); else n_pass++;
    n_chk++; if ({dir_b, en_b, busy_b, cv_b, md_b} !== 5'b0) $display("FAIL rst_b got %b exp 00000", {dir_b, en_b, busy_b, cv_b, md_b}); else n_pass++;
    Resetn = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_pwm;
    bit ok;
    int h, r, e;
    duty_cycle = 7'd30;
    repeat (250) @(negedge Clk);
    wait_en_rise(ok);
    n_chk++; if (!ok) $display("FAIL pwm30_sync got timeout exp en rise"); else n_pass++;
    exp_q.push_back(30);
    exp_q.push_back(1);
    measure(-1, 7'd0, h, r);
    e = exp_q.pop_front();
    n_chk++; if (h !== e) $display("FAIL pwm30_high got %0d exp %0d", h, e); else n_pass++;
    e = exp_q.pop_front();
    n_chk++; if (r !== e) $display("FAIL pwm30_runs got %0d exp %0d", r, e); else n_pass++;
    duty_cycle = 7'd0;
    repeat (250) @(negedge Clk);
    exp_q.push_back(0);
    measure(-1, 7'd0, h, r);
    e = exp_q.pop_front();
    n_chk++; if (h !== e) $display("FAIL pwm0_high got %0d exp %0d", h, e); else n_pass++;
    duty_cycle = 7'd127;
    repeat (250) @(negedge Clk);
    exp_q.push_back(100);
    measure(-1, 7'd0, h, r);
    e = exp_q.pop_front();
    n_chk++; if (h !== e) $display("FAIL pwm127_high got %0d exp %0d", h, e); else n_pass++;
  endtask

  task automatic test_duty_change;
    bit ok;
    int h, r, e;
    duty_cycle = 7'd30;
    repeat (250) @(negedge Clk);
    wait_en_rise(ok);
    n_chk++; if (!ok) $display("FAIL chg_sync1 got timeout exp en rise"); else n_pass++;
    exp_q.push_back(30);
    exp_q.push_back(1);
    measure(40, 7'd70, h, r);
    e = exp_q.pop_front();
    n_chk++; if (h !== e) $display("FAIL chg_cur_high got %0d exp %0d", h, e); else n_pass++;
    e = exp_q.pop_front();
    n_chk++; if (r !== e) $display("FAIL chg_cur_runs got %0d exp %0d", r, e); else n_pass++;
    wait_en_rise(ok);
    n_chk++; if (!ok) $display("FAIL chg_sync2 got timeout exp en rise"); else n_pass++;
    exp_q.push_back(70);
    exp_q.push_back(1);
    measure(-1, 7'd0, h, r);
    e = exp_q.pop_front();
    n_chk++; if (h !== e) $display("FAIL chg_next_high got %0d exp %0d", h, e); else n_pass++;
    e = exp_q.pop_front();
    n_chk++; if (r !== e) $display("FAIL chg_next_runs got %0d exp %0d", r, e); else n_pass++;
  endtask

  task automatic test_dead_time;
    int busy, enlow, flip, bad, e;
    logic pd, pe;
    duty_cycle = 7'd127;
    repeat (250) @(negedge Clk);
    busy = 0; enlow = 0; flip = -1; bad = 0;
    pd = dir_a; pe = en_a;
    dir_req = 1'b1;
    exp_q.push_back(20);
    exp_q.push_back(20);
    exp_q.push_back(10);
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (busy_a) busy++;
      if (!en_a) enlow++;
      if (dir_a && flip < 0) flip = i;
      if ((dir_a != pd) && (en_a || pe)) bad++;
      pd = dir_a; pe = en_a;
    end
    e = exp_q.pop_front();
    n_chk++; if (busy !== e) $display("FAIL dt_busy got %0d exp %0d", busy, e); else n_pass++;
    e = exp_q.pop_front();
    n_chk++; if (enlow !== e) $display("FAIL dt_enlow got %0d exp %0d", enlow, e); else n_pass++;
    e = exp_q.pop_front();
    n_chk++; if (flip !== e) $display("FAIL dt_flip got %0d exp %0d", flip, e); else n_pass++;
    n_chk++; if (bad !== 0) $display("FAIL dt_dir_with_en got %0d exp 0", bad); else n_pass++;
    n_chk++; if (en_a !== 1'b1) $display("FAIL dt_resume got %0b exp 1", en_a); else n_pass++;
  endtask

  task automatic test_toggle_back;
    int busy, lows;
    busy = 0; lows = 0;
    dir_req = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (busy_a) busy++;
      if (!dir_a) lows++;
      if (i == 2) dir_req = 1'b1;
    end
    n_chk++; if (busy !== 20) $display("FAIL tb_busy got %0d exp 20", busy); else n_pass++;
    n_chk++; if (lows !== 0) $display("FAIL tb_dir_kept got %0d low samples exp 0", lows); else n_pass++;
  endtask

  task automatic test_pulse_count;
    bit ok;
    int e;
    wait_valid(ok);
    n_chk++; if (!ok) $display("FAIL pc_sync got timeout exp count_valid"); else n_pass++;
    exp_q.push_back(25);
    exp_q.push_back(50);
    drive_pulses(25, 1'b1);
    wait_valid(ok);
    n_chk++; if (!ok) $display("FAIL pc_gate got timeout exp count_valid"); else n_pass++;
    e = exp_q.pop_front();
    n_chk++; if (pc_a !== 32'(e)) $display("FAIL pc_rise got %0d exp %0d", pc_a, e); else n_pass++;
    e = exp_q.pop_front();
    n_chk++; if (pc_b !== 32'(e)) $display("FAIL pc_both got %0d exp %0d", pc_b, e); else n_pass++;
    @(negedge Clk);
    n_chk++; if ({cv_a, cv_b} !== 2'b00) $display("FAIL pc_strobe_len got %b exp 00", {cv_a, cv_b}); else n_pass++;
  endtask

  task automatic test_meas_dir;
    n_chk++; if ({md_a, md_b} !== 2'b11) $display("FAIL md_lead got %b exp 11", {md_a, md_b}); else n_pass++;
    drive_pulses(5, 1'b0);
    n_chk++; if ({md_a, md_b} !== 2'b00) $display("FAIL md_lag got %b exp 00", {md_a, md_b}); else n_pass++;
  endtask

  task automatic test_gate_boundary;
    bit ok;
    int e;
    logic [31:0] c0a, c0b;
    wait_valid(ok);
    n_chk++; if (!ok) $display("FAIL gb_sync got timeout exp count_valid"); else n_pass++;
    exp_q.push_back(11);
    exp_q.push_back(21);
    exp_q.push_back(4);
    exp_q.push_back(9);
    drive_pulses(10, 1'b1);
    repeat (797) @(negedge Clk);
    SA = 1'b1;
    SB = 1'b1;
    repeat (3) @(negedge Clk);
    n_chk++; if ({cv_a, cv_b} !== 2'b11) $display("FAIL gb_strobe got %b exp 11", {cv_a, cv_b}); else n_pass++;
    c0a = pc_a;
    c0b = pc_b;
    e = exp_q.pop_front();
    n_chk++; if (c0a !== 32'(e)) $display("FAIL gb_close_rise got %0d exp %0d", c0a, e); else n_pass++;
    e = exp_q.pop_front();
    n_chk++; if (c0b !== 32'(e)) $display("FAIL gb_close_both got %0d exp %0d", c0b, e); else n_pass++;
    repeat (7) @(negedge Clk);
    SA = 1'b0;
    repeat (10) @(negedge Clk);
    drive_pulses(4, 1'b1);
    wait_valid(ok);
    n_chk++; if (!ok) $display("FAIL gb_next got timeout exp count_valid"); else n_pass++;
    e = exp_q.pop_front();
    n_chk++; if (pc_a !== 32'(e)) $display("FAIL gb_next_rise got %0d exp %0d", pc_a, e); else n_pass++;
    e = exp_q.pop_front();
    n_chk++; if (pc_b !== 32'(e)) $display("FAIL gb_next_both got %0d exp %0d", pc_b, e); else n_pass++;
    n_chk++; if (c0a + pc_a !== 32'd15) $display("FAIL gb_total_rise got %0d exp 15", c0a + pc_a); else n_pass++;
    n_chk++; if (c0b + pc_b !== 32'd30) $display("FAIL gb_total_both got %0d exp 30", c0b + pc_b); else n_pass++;
  endtask

  task automatic test_reset_mid_dead;
    dir_req = 1'b0;
    repeat (5) @(negedge Clk);
    n_chk++; if (busy_a !== 1'b1) $display("FAIL rd_busy_before got %0b exp 1", busy_a); else n_pass++;
    Resetn = 1'b0;
    #1;
    n_chk++; if (dir_a !== 1'b0) $display("FAIL rd_dir got %0b exp 0", dir_a); else n_pass++;
    n_chk++; if (en_a !== 1'b0) $display("FAIL rd_en got %0b exp 0", en_a); else n_pass++;
    n_chk++; if (busy_a !== 1'b0) $display("FAIL rd_busy got %0b exp 0", busy_a); else n_pass++;
    n_chk++; if (pc_a !== 32'd0) $display("FAIL rd_pc got %0d exp 0", pc_a); else n_pass++;
    n_chk++; if (cv_a !== 1'b0) $display("FAIL rd_cv got %0b exp 0", cv_a); else n_pass++;
    n_chk++; if (md_a !== 1'b0) $display("FAIL rd_md got %0b exp 0", md_a); else n_pass++;
    repeat (3) @(negedge Clk);
    Resetn = 1'b1;
    repeat (5) @(negedge Clk);
    n_chk++; if ({busy_a, dir_a} !== 2'b00) $display("FAIL rd_run got %b exp 00", {busy_a, dir_a}); else n_pass++;
    repeat (150) @(negedge Clk);
    n_chk++; if (en_a !== 1'b1) $display("FAIL rd_pwm got %0b exp 1", en_a); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_pwm();
    test_duty_change();
    test_dead_time();
    test_toggle_back();
    test_pulse_count();
    test_meas_dir();
    test_gate_boundary();
    test_reset_mid_dead();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
